// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data SRAM.
//
// The pipeline MEM stage (cpu_*) and an external load/store port (ext_*) share
// one SRAM port. Grants are combinational in the request cycle; read data
// comes back one cycle later and is routed by the registered owner state.
//
// Ports:
//   clk, srst                       clock, synchronous active-high reset
//   cpu_req/wen/addr/wdata          pipeline request (held until cpu_gnt)
//   cpu_gnt/rvalid/rdata/stall      pipeline grant, read response, stall
//   ext_req/wen/addr/wdata          external request (held until ext_gnt)
//   ext_gnt/rvalid/rdata            external grant and read response
//   mem_en/wen/addr/wdata           SRAM request
//   mem_rdata                       SRAM read data, one cycle after a read
//
// Configuration macro DMEM_ARB_RR_EN:
//   undefined - CPU wins ties unless EXT has waited MAX_EXT_WAIT cycles
//   defined   - ties alternate between requesters (last_ext_q)

module dmem_arbiter #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned MAX_EXT_WAIT = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StCpuOwn, StExtOwn} state_e;

    state_e state_q, state_d;
    logic   rd_pend_q, rd_pend_d;  // last cycle's grant was a read
    logic   ext_pri;               // EXT wins a tie this cycle
    logic   tie;

    assign tie = cpu_req & ext_req;

`ifdef DMEM_ARB_RR_EN
    logic last_ext_q, last_ext_d;  // 1: EXT won the previous tie

    assign ext_pri = ~last_ext_q;

    always_comb begin
        last_ext_d = last_ext_q;
        if (tie && !srst) begin
            last_ext_d = ext_gnt;
        end
    end
`else
    localparam logic [3:0] MaxWait = 4'(MAX_EXT_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;

    assign ext_pri = (wait_cnt_q == MaxWait);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!ext_req || ext_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end
`endif

    // Grant decision; requests are ignored while in reset.
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (!srst) begin
            if (cpu_req && (!ext_req || !ext_pri)) begin
                cpu_gnt = 1'b1;
            end else if (ext_req) begin
                ext_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = cpu_gnt | ext_gnt;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_wen   = cpu_wen;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_gnt) begin
            mem_wen   = ext_wen;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    always_comb begin
        state_d   = cpu_gnt ? StCpuOwn : (ext_gnt ? StExtOwn : StIdle);
        rd_pend_d = mem_en & ~mem_wen;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= StIdle;
            rd_pend_q  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_ext_q <= 1'b1;
`else
            wait_cnt_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
`ifdef DMEM_ARB_RR_EN
            last_ext_q <= last_ext_d;
`else
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // Read response routed by the owner of last cycle's grant.
    always_comb begin
        cpu_rvalid = ~srst & rd_pend_q & (state_q == StCpuOwn);
        ext_rvalid = ~srst & rd_pend_q & (state_q == StExtOwn);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        ext_rdata  = ext_rvalid ? mem_rdata : '0;
        cpu_stall  = ~srst & cpu_req & ~cpu_gnt;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of per-cycle vectors followed
// by hand-written contention sequences for the tie-break policy.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        srst;
    logic        cpu_req, cpu_wen, ext_req, ext_wen;
    logic [63:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid;
    logic        mem_en, mem_wen;
    logic [63:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W      (64),
        .ADDR_W      (64),
        .MAX_EXT_WAIT(4)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .cpu_req   (cpu_req),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_wen   (ext_wen),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_gnt   (ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata (ext_rdata),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        string       name;
        logic        sr;
        logic        cr, cw;
        logic [63:0] ca, cd;
        logic        er, ew;
        logic [63:0] ea, ed;
        logic [63:0] mrd;
        logic [6:0]  flags;  // {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_stall, mem_en, mem_wen}
        logic [63:0] crd, erd, maddr, mwd;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input string nm, input logic sr, input logic cr, input logic cw,
                                input logic [63:0] ca, input logic [63:0] cd, input logic er,
                                input logic ew, input logic [63:0] ea, input logic [63:0] ed,
                                input logic [63:0] mrd, input logic [6:0] flags,
                                input logic [63:0] crd, input logic [63:0] erd,
                                input logic [63:0] maddr, input logic [63:0] mwd);
        vec_t v;
        v.name = nm; v.sr = sr; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.er = er; v.ew = ew; v.ea = ea; v.ed = ed; v.mrd = mrd; v.flags = flags;
        v.crd = crd; v.erd = erd; v.maddr = maddr; v.mwd = mwd;
        return v;
    endfunction

    function automatic logic [319:0] outs();
        return 320'({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_stall, mem_en, mem_wen,
                     cpu_rdata, ext_rdata, mem_addr, mem_wdata});
    endfunction

    task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sr, input logic cr, input logic cw, input logic [63:0] ca,
                         input logic [63:0] cd, input logic er, input logic ew,
                         input logic [63:0] ea, input logic [63:0] ed, input logic [63:0] mrd);
        srst = sr; cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = ed; mem_rdata = mrd;
    endtask

    // One contention cycle: reads from both sides, check grant, stall and address.
    task automatic cyc(input string nm, input logic cr, input logic er, input logic exp_c,
                       input logic exp_e);
        logic [63:0] exp_a;
        drive(1'b0, cr, 1'b0, 64'h100, 64'h0, er, 1'b0, 64'h200, 64'h0, 64'h0);
        @(negedge clk);
        exp_a = exp_c ? 64'h100 : (exp_e ? 64'h200 : 64'h0);
        check(nm, 320'({cpu_gnt, ext_gnt, cpu_stall, mem_addr}),
              320'({exp_c, exp_e, cr & ~exp_c, exp_a}));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [5:0] exp_c;
        //                 name         sr cr cw ca     cd     er ew ea     ed     mrd      flags        crd      erd      maddr  mwd
        tbl[0]  = mk("cpu_rd",          0, 1, 0, 'h10, 0,     0, 0, 0,     0,     0,       7'b1000010, 0,       0,       'h10, 0);
        tbl[1]  = mk("cpu_rv",          0, 0, 0, 0,     0,     0, 0, 0,     0,     'hDEAD, 7'b0010000, 'hDEAD, 0,       0,     0);
        tbl[2]  = mk("rv_one_cycle",    0, 0, 0, 0,     0,     0, 0, 0,     0,     'h1234, 7'b0000000, 0,       0,       0,     0);
        tbl[3]  = mk("ext_wr",          0, 0, 0, 0,     0,     1, 1, 'h20, 'h55, 0,       7'b0100011, 0,       0,       'h20, 'h55);
        tbl[4]  = mk("no_rv_after_wr",  0, 0, 0, 0,     0,     0, 0, 0,     0,     'hBEEF, 7'b0000000, 0,       0,       0,     0);
        tbl[5]  = mk("cpu_rd2",         0, 1, 0, 'h30, 0,     0, 0, 0,     0,     0,       7'b1000010, 0,       0,       'h30, 0);
        tbl[6]  = mk("ext_rd_cpu_rv",   0, 0, 0, 0,     0,     1, 0, 'h40, 0,     'hAAAA, 7'b0110010, 'hAAAA, 0,       'h40, 0);
        tbl[7]  = mk("ext_rv",          0, 0, 0, 0,     0,     0, 0, 0,     0,     'hBBBB, 7'b0001000, 0,       'hBBBB, 0,     0);
        tbl[8]  = mk("cpu_wr",          0, 1, 1, 'h50, 'h77, 0, 0, 0,     0,     0,       7'b1000011, 0,       0,       'h50, 'h77);
        tbl[9]  = mk("no_rv_cpu_wr",    0, 0, 0, 0,     0,     0, 0, 0,     0,     'h99,   7'b0000000, 0,       0,       0,     0);
        tbl[10] = mk("ext_rd",          0, 0, 0, 0,     0,     1, 0, 'h60, 0,     0,       7'b0100010, 0,       0,       'h60, 0);
        tbl[11] = mk("cpu_rd_ext_rv",   0, 1, 0, 'h70, 0,     0, 0, 0,     0,     'hCC,   7'b1001010, 0,       'hCC,   'h70, 0);
        tbl[12] = mk("cpu_rv3",         0, 0, 0, 0,     0,     0, 0, 0,     0,     'hDD,   7'b0010000, 'hDD,   0,       0,     0);
        tbl[13] = mk("pre_rst_rd",      0, 1, 0, 'h80, 0,     0, 0, 0,     0,     0,       7'b1000010, 0,       0,       'h80, 0);
        tbl[14] = mk("in_rst",          1, 1, 0, 'h80, 0,     1, 0, 'h90, 0,     'hEE,   7'b0000000, 0,       0,       0,     0);
        tbl[15] = mk("post_rst_rd",     0, 1, 0, 'h90, 0,     0, 0, 0,     0,     'hEE,   7'b1000010, 0,       0,       'h90, 0);
        tbl[16] = mk("post_rst_rv",     0, 0, 0, 0,     0,     0, 0, 0,     0,     'hFF,   7'b0010000, 'hFF,   0,       0,     0);

        // Reset with both requesting: everything must stay quiet.
        drive(1'b1, 1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b1, 64'h20, 64'h55, 64'h1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", outs(), 320'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].sr, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].er, tbl[i].ew,
                  tbl[i].ea, tbl[i].ed, tbl[i].mrd);
            @(negedge clk);
            check(tbl[i].name, outs(),
                  320'({tbl[i].flags, tbl[i].crd, tbl[i].erd, tbl[i].maddr, tbl[i].mwd}));
            @(posedge clk); #1;
        end

        // Continuous contention; bit i is the expected CPU grant in cycle i.
`ifdef DMEM_ARB_RR_EN
        exp_c = 6'b010101;
`else
        exp_c = 6'b101111;
`endif
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("contend_c%0d", i), 1'b1, 1'b1, exp_c[i], ~exp_c[i]);
        end
        cyc("contend_idle", 1'b0, 1'b0, 1'b0, 1'b0);

`ifndef DMEM_ARB_RR_EN
        // Wait counter must clear when EXT drops its request.
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("age_pre_c%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
        end
        cyc("age_ext_drop", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("age_post_c%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
        end
        cyc("age_ext_forced", 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("age_cpu_again", 1'b1, 1'b1, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64: width of read and write data.
REQ-002 The block SHALL have parameter ADDR_W, default 64: width of the byte address.
REQ-003 The block SHALL have parameter MAX_EXT_WAIT, default 4: cycles the external requester may be refused before it gets forced priority (range 1..15).
REQ-004 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 The block SHALL have port srst, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have ports cpu_req, cpu_wen (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W): pipeline MEM-stage access request.
REQ-007 The block SHALL have ports cpu_gnt, cpu_rvalid (output, 1), cpu_rdata (output, DATA_W) and cpu_stall (output, 1): pipeline response and stall.
REQ-008 The block SHALL have ports ext_req, ext_wen (input, 1), ext_addr (input, ADDR_W) and ext_wdata (input, DATA_W): external load/store request.
REQ-009 The block SHALL have ports ext_gnt, ext_rvalid (output, 1) and ext_rdata (output, DATA_W): external response.
REQ-010 The block SHALL have ports mem_en, mem_wen (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): single-port data SRAM request.
REQ-011 The block SHALL have port mem_rdata, input, DATA_W: SRAM read data, valid one cycle after a read request.

Function
REQ-012 Grant SHALL be combinational in the request cycle, and at most one of cpu_gnt and ext_gnt SHALL be high in any cycle.
REQ-013 mem_en SHALL equal cpu_gnt|ext_gnt, and mem_wen/mem_addr/mem_wdata SHALL be taken from the granted requester (all zero when neither is granted).
REQ-014 A requester SHALL hold req, wen, addr and wdata stable until it sees gnt; the arbiter SHALL NOT latch a payload that has not been granted.
REQ-015 A single requester SHALL be granted in the same cycle; back-to-back grants SHALL be possible every cycle with no bubble.
REQ-016 Read latency: one cycle after a granted read, the owner's rvalid SHALL pulse high for exactly one cycle, and its rdata SHALL equal mem_rdata.
REQ-017 Read routing SHALL use a registered owner tag; rdata of the non-owner SHALL be zero.
REQ-018 A granted write SHALL produce no rvalid.
REQ-019 cpu_stall SHALL equal cpu_req & ~cpu_gnt.
REQ-020 Default policy: CPU wins a tie unless ext_wait_cnt == MAX_EXT_WAIT, in which case EXT wins.
REQ-021 ext_wait_cnt SHALL increment each cycle that ext_req & ~ext_gnt, saturating at MAX_EXT_WAIT.
REQ-022 ext_wait_cnt SHALL clear on ext_gnt or when ext_req is low.
REQ-023 Policy FSM states: IDLE (no grant last cycle), CPU_OWN, EXT_OWN (owner of last grant); the next state SHALL be the current winner, or IDLE when there is no request.
REQ-024 The FSM state SHALL drive the owner tag used in REQ-017.
REQ-025 Requests arriving while a read response is pending SHALL be arbitrated normally; the response and the new grant SHALL coexist in one cycle.

Reset
REQ-026 While srst is high, all gnt, rvalid, rdata, mem_en, mem_wen and cpu_stall outputs SHALL be 0, with requests ignored.
REQ-027 Reset SHALL put the FSM in IDLE, set ext_wait_cnt to 0 and last_winner to EXT.
REQ-028 A read granted in the cycle before srst asserts SHALL NOT produce rvalid after reset.
REQ-029 The first cycle after srst deasserts SHALL arbitrate normally.

Configuration
REQ-030 With macro DMEM_ARB_RR_EN defined, ties SHALL go to the requester that did not win the previous tie (last_winner register), and ext_wait_cnt SHALL be absent, with no effect on grants.
REQ-031 Without DMEM_ARB_RR_EN, arbitration SHALL be fixed-priority with aging per REQ-020 to REQ-022.

Verification
REQ-032 CPU read addr 0x10 only, mem_rdata=0xDEAD in the next cycle -> cpu_gnt=1 in cycle 0; cpu_rvalid=1 and cpu_rdata=0xDEAD in cycle 1; ext_rvalid=0.
REQ-033 Both request continuously, no macro, MAX_EXT_WAIT=4 -> CPU granted cycles 0-3, EXT granted cycle 4, cpu_stall=1 only in cycle 4.
REQ-034 Both request continuously, DMEM_ARB_RR_EN -> grants alternate CPU, EXT, CPU, EXT starting with CPU.
REQ-035 EXT write addr 0x20 data 0x55 with no CPU request -> mem_en=1, mem_wen=1, mem_addr=0x20, mem_wdata=0x55 in the same cycle; no rvalid afterwards.
REQ-036 CPU read granted, srst high in the next cycle -> cpu_rvalid stays 0; all outputs 0 during reset.
REQ-037 CPU read in cycle 0 and EXT read in cycle 1 -> cpu_rvalid in cycle 1 and ext_rvalid in cycle 2, each with the matching mem_rdata.
